led_shift_ctrl: RTL

Run/pause controller for the LED shift-register display, driven by the debounced encoder and push-button front end. It schedules periodic rotation of a one-hot LED pattern from an internal prescaler. It shares the encoder step stream between two uses: speed adjustment while idle or running, and manual single-stepping while paused. It sits between the encoder front end (debounce plus edge detector) and the LED output register.

---
 rtl/led_shift_ctrl_pkg.sv | 19 +
 rtl/led_shift_ctrl_tick_gen.sv | 28 ++
 rtl/led_shift_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/led_shift_ctrl_pkg.sv
// Shared definitions for the LED shift controller: FSM state encoding and
// prescaler sizing.
package led_shift_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Bits needed to hold the longest reload value, 2^speed_w * base_div - 1.
    function automatic int unsigned presc_width(input int unsigned speed_w,
                                                input int unsigned base_div);
        int unsigned cycles_max;
        cycles_max = (32'd1 << speed_w) * base_div;
        return (cycles_max > 32'd1) ? $clog2(cycles_max) : 1;
    endfunction

endpackage

// File: rtl/led_shift_ctrl_tick_gen.sv
// Reloadable down-counter prescaler; expire is high on the cycle the count
// sits at zero while enabled, and the counter reloads on that same edge.
module tick_gen #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] period,
    output logic         expire
);

    logic [W-1:0] count;

    assign expire = en && (count == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= period;
        end else if (en) begin
            count <= (count == '0) ? period : count - 1'b1;
        end
    end

endmodule

// File: rtl/led_shift_ctrl.sv
// Run/pause controller for the rotating one-hot LED display: button-driven
// FSM, saturating speed register, LED rotator and prescaler instance.
module led_shift_ctrl
    import led_shift_ctrl_pkg::*;
#(
    parameter int unsigned LED_N    = 8,
    parameter int unsigned SPEED_W  = 3,
    parameter int unsigned BASE_DIV = 65536
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step,
    input  logic               step_dir,
    input  logic               btn,
    input  logic               shift_dir,
    output logic [LED_N-1:0]   led,
    output logic [SPEED_W-1:0] speed,
    output logic               running,
    output logic               tick
);

    localparam int unsigned PW    = presc_width(SPEED_W, BASE_DIV);
    localparam int unsigned STEPS = 32'd1 << SPEED_W;

    state_t             state;
    logic               btn_q;
    logic               btn_armed;
    logic               btn_rise;
    logic               expire;
    logic               load;
    logic               en;
    logic [PW-1:0]      period;
    logic [LED_N-1:0]   led_rot;
    logic [SPEED_W-1:0] speed_next;

    // A button held across reset release must not count as an edge, so a
    // rise is only accepted once the button has been seen low.
    assign btn_rise = btn && !btn_q && btn_armed;
    assign load     = btn_rise && (state != ST_RUN);
    assign en       = (state == ST_RUN);

    always_comb begin
        period     = PW'(BASE_DIV * (STEPS - 32'(speed)) - 32'd1);
        led_rot    = shift_dir ? {led[LED_N-2:0], led[LED_N-1]}
                               : {led[0], led[LED_N-1:1]};
        speed_next = speed;
        if (step_dir) begin
            if (speed != '1) speed_next = speed + 1'b1;
        end else begin
            if (speed != '0) speed_next = speed - 1'b1;
        end
    end

    tick_gen #(
        .W (PW)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .load   (load),
        .period (period),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            led       <= LED_N'(1);
            speed     <= '0;
            running   <= 1'b0;
            tick      <= 1'b0;
            btn_q     <= 1'b0;
            btn_armed <= 1'b0;
        end else begin
            btn_q <= btn;
            if (!btn) btn_armed <= 1'b1;
            tick <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (step) speed <= speed_next;
                    if (btn_rise) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (step) speed <= speed_next;
                    // Leaving RUN wins over a coincident expiry: no shift.
                    if (btn_rise) begin
                        state   <= ST_PAUSE;
                        running <= 1'b0;
                    end else if (expire) begin
                        led  <= led_rot;
                        tick <= 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (step) begin
                        led  <= led_rot;
                        tick <= 1'b1;
                    end
                    if (btn_rise) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule
